// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: vga_timing_gen drives it through the master modport,
// and the tile engine, sprite engine and line buffer read it through the slave modport.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
    parameter int XW = 11,
    parameter int YW = 10
);
    logic          enable;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_ce;
    logic          active;
    logic          vga_clk;
    logic          hsync;
    logic          vsync;
    logic          blank_n;
    logic          sync_n;
    logic          render_start;
    logic [YW-1:0] render_line;
    logic          buf_swap;
    logic          vblank_start;
    logic          frame_start;
    logic [15:0]   frame_count;
    logic [YW-1:0] irq_line;
    logic          irq_ack;
    logic          irq_pending;

    modport master (
        input  enable, irq_line, irq_ack,
        output pix_x, pix_y, pix_ce, active, vga_clk, hsync, vsync, blank_n,
               sync_n, render_start, render_line, buf_swap, vblank_start,
               frame_start, frame_count, irq_pending
    );

    modport slave (
        output enable, irq_line, irq_ack,
        input  pix_x, pix_y, pix_ce, active, vga_clk, hsync, vsync, blank_n,
               sync_n, render_start, render_line, buf_swap, vblank_start,
               frame_start, frame_count, irq_pending
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with render/swap/vblank scheduling strobes.
// Defining VGA_TIMING_LINE_IRQ_EN adds a sticky line-compare interrupt.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int SWAP_LEAD = 5,
    parameter int XW        = 11,
    parameter int YW        = 10
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW       = 3;
    localparam int SWAP_IDX = H_TOTAL * CLK_DIV - SWAP_LEAD;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] SWAP_DIV = DW'(SWAP_IDX % CLK_DIV);
    localparam logic [XW-1:0] SWAP_X   = XW'(SWAP_IDX / CLK_DIV);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_STOP  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_STOP  = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    logic [DW-1:0] div;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [15:0]   frame_count;
    logic [YW-1:0] render_line;
    logic          run;
    logic          pix_start;
    logic          render_ok;
    logic          vblank_start;

    // Pulses are qualified by reset as well so nothing strobes while reset is held.
    assign run       = bus.enable & ~reset;
    assign pix_start = run & (div == '0) & (pix_x == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div         <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_count <= '0;
        end else if (bus.enable) begin
            if (div == DIV_LAST) begin
                div <= '0;
                if (pix_x == H_LAST) begin
                    pix_x <= '0;
                    pix_y <= (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
                end else begin
                    pix_x <= pix_x + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
            if (vblank_start) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    assign render_line  = (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
    assign render_ok    = (render_line < V_ACT);
    assign vblank_start = pix_start & (pix_y == V_ACT);

    assign bus.pix_x        = pix_x;
    assign bus.pix_y        = pix_y;
    assign bus.pix_ce       = run & (div == '0);
    assign bus.active       = (pix_x < H_ACT) & (pix_y < V_ACT);
    assign bus.blank_n      = (pix_x < H_ACT) & (pix_y < V_ACT);
    assign bus.sync_n       = 1'b0;
    assign bus.vga_clk      = (div >= DIV_HALF);
    assign bus.hsync        = ((pix_x >= HS_START) && (pix_x < HS_STOP)) ? HS_ON : ~HS_ON;
    assign bus.vsync        = ((pix_y >= VS_START) && (pix_y < VS_STOP)) ? VS_ON : ~VS_ON;
    assign bus.render_line  = render_line;
    assign bus.render_start = pix_start & render_ok;
    // Swap point is a linear clock index, split here into pixel column and divider phase.
    assign bus.buf_swap     = run & (pix_x == SWAP_X) & (div == SWAP_DIV) & render_ok;
    assign bus.vblank_start = vblank_start;
    assign bus.frame_start  = pix_start & (pix_y == '0);
    assign bus.frame_count  = frame_count;

`ifdef VGA_TIMING_LINE_IRQ_EN
    logic irq_pending;

    // A new line match takes priority over an acknowledge on the same clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_pending <= 1'b0;
        end else if (pix_start && (pix_y == bus.irq_line)) begin
            irq_pending <= 1'b1;
        end else if (bus.irq_ack) begin
            irq_pending <= 1'b0;
        end
    end

    assign bus.irq_pending = irq_pending;
`else
    logic irq_unused;

    assign irq_unused      = ^{bus.irq_line, bus.irq_ack};
    assign bus.irq_pending = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 640x480 instance and a tiny CLK_DIV=4 raster run side by side
// on shared stimulus, checked every clock against a scoreboard plus a table of hand-derived points.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int NVEC = 20;

    typedef struct packed {
        logic [XW-1:0] pix_x;
        logic [YW-1:0] pix_y;
        logic          pix_ce;
        logic          active;
        logic          vga_clk;
        logic          hsync;
        logic          vsync;
        logic          blank_n;
        logic          sync_n;
        logic          render_start;
        logic [YW-1:0] render_line;
        logic          buf_swap;
        logic          vblank_start;
        logic          frame_start;
        logic [15:0]   frame_count;
        logic          irq_pending;
    } obs_t;

    typedef struct {
        int cd; int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb; int lead;
    } cfg_t;

    typedef struct {
        int         t;
        bit         sel;
        int         x;
        int         y;
        logic [8:0] flags;
        logic [8:0] mask;
        int         fc;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [YW-1:0] irq_line;
    logic          irq_ack;

    int   checks;
    int   errors;
    cfg_t cfg_a;
    cfg_t cfg_b;
    int   t_a, t_b, fc_a, fc_b;
    logic pend_a, pend_b;
    int   last_t;
    obs_t obs_a, obs_b, samp_a, samp_b;
    obs_t exp_q_a[$];
    obs_t exp_q_b[$];
    vec_t vecs[NVEC];

    vga_timing_gen_if #(.XW(XW), .YW(YW)) bus_a ();
    vga_timing_gen_if #(.XW(XW), .YW(YW)) bus_b ();

    assign bus_a.enable   = enable;
    assign bus_a.irq_line = irq_line;
    assign bus_a.irq_ack  = irq_ack;
    assign bus_b.enable   = enable;
    assign bus_b.irq_line = irq_line;
    assign bus_b.irq_ack  = irq_ack;

    vga_timing_gen dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .SWAP_LEAD(3), .XW(XW), .YW(YW)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    assign obs_a = {bus_a.pix_x, bus_a.pix_y, bus_a.pix_ce, bus_a.active, bus_a.vga_clk,
                    bus_a.hsync, bus_a.vsync, bus_a.blank_n, bus_a.sync_n, bus_a.render_start,
                    bus_a.render_line, bus_a.buf_swap, bus_a.vblank_start, bus_a.frame_start,
                    bus_a.frame_count, bus_a.irq_pending};
    assign obs_b = {bus_b.pix_x, bus_b.pix_y, bus_b.pix_ce, bus_b.active, bus_b.vga_clk,
                    bus_b.hsync, bus_b.vsync, bus_b.blank_n, bus_b.sync_n, bus_b.render_start,
                    bus_b.render_line, bus_b.buf_swap, bus_b.vblank_start, bus_b.frame_start,
                    bus_b.frame_count, bus_b.irq_pending};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timing derived from the count of enabled clocks since reset.
    function automatic obs_t model(input cfg_t c, input int t, input logic en, input logic rst,
                                   input int fc, input logic pend);
        obs_t o;
        int   ht, vt, dv, x, y, rl;
        logic run, start;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        dv    = t % c.cd;
        x     = (t / c.cd) % ht;
        y     = (t / (c.cd * ht)) % vt;
        rl    = (y + 1) % vt;
        run   = en & ~rst;
        start = run && (dv == 0) && (x == 0);
        o.pix_x        = XW'(x);
        o.pix_y        = YW'(y);
        o.pix_ce       = run && (dv == 0);
        o.active       = (x < c.ha) && (y < c.va);
        o.vga_clk      = (dv >= c.cd / 2);
        o.hsync        = !((x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs));
        o.vsync        = !((y >= c.va + c.vf) && (y < c.va + c.vf + c.vs));
        o.blank_n      = o.active;
        o.sync_n       = 1'b0;
        o.render_start = start && (rl < c.va);
        o.render_line  = YW'(rl);
        o.buf_swap     = run && ((t % (c.cd * ht)) == c.cd * ht - c.lead) && (rl < c.va);
        o.vblank_start = start && (y == c.va);
        o.frame_start  = start && (y == 0);
        o.frame_count  = 16'(fc);
        o.irq_pending  = pend;
        return o;
    endfunction

    function automatic logic [8:0] flagsOf(input obs_t o);
        return {o.pix_ce, o.vga_clk, o.hsync, o.vsync, o.blank_n,
                o.render_start, o.buf_swap, o.vblank_start, o.frame_start};
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0d: got %h expected %h", name, last_t, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic advance(inout int t, inout int fc, inout logic pend, input obs_t e,
                           input logic en, input logic ack);
`ifdef VGA_TIMING_LINE_IRQ_EN
        if (e.pix_ce && (e.pix_x == '0) && (e.pix_y == irq_line)) pend = 1'b1;
        else if (ack) pend = 1'b0;
`else
        pend = pend & ~ack & 1'b0;
`endif
        if (e.vblank_start) fc++;
        if (en) t++;
    endtask

    // One clock: drive on the falling edge, queue expectations, sample 1 ns later.
    task automatic applyStimulus(input logic rst, input logic en, input logic ack);
        obs_t e_a, e_b;
        @(negedge clk);
        reset   = rst;
        enable  = en;
        irq_ack = ack;
        if (rst) begin
            t_a = 0; t_b = 0; fc_a = 0; fc_b = 0; pend_a = 1'b0; pend_b = 1'b0;
        end
        exp_q_a.push_back(model(cfg_a, t_a, en, rst, fc_a, pend_a));
        exp_q_b.push_back(model(cfg_b, t_b, en, rst, fc_b, pend_b));
        #1;
        samp_a = obs_a;
        samp_b = obs_b;
        last_t = rst ? -1 : t_a;
        e_a = exp_q_a.pop_front();
        e_b = exp_q_b.pop_front();
        checkOutput("scoreboard_a", samp_a, e_a);
        checkOutput("scoreboard_b", samp_b, e_b);
        if (!rst) begin
            advance(t_a, fc_a, pend_a, e_a, en, ack);
            advance(t_b, fc_b, pend_b, e_b, en, ack);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   guard;
        int   cnt;
        obs_t s;
        logic seen;

        checks = 0; errors = 0;
        reset = 1'b1; enable = 1'b0; irq_ack = 1'b0; irq_line = 10'd3;
        t_a = 0; t_b = 0; fc_a = 0; fc_b = 0; pend_a = 1'b0; pend_b = 1'b0; last_t = -1;
        cfg_a = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 5};
        cfg_b = '{4, 16, 2, 2, 2, 4, 1, 1, 1, 3};

        // flags: pix_ce vga_clk hsync vsync blank_n render_start buf_swap vblank_start frame_start
        vecs[0]  = '{0,    1'b0, 0,   0, 9'b101111001, 9'h1FF, 0};
        vecs[1]  = '{1,    1'b0, 0,   0, 9'b011110000, 9'h1FF, 0};
        vecs[2]  = '{1,    1'b1, 0,   0, 9'b001110000, 9'h1FF, 0};
        vecs[3]  = '{2,    1'b1, 0,   0, 9'b010000000, 9'h180, -1};
        vecs[4]  = '{85,   1'b1, 21,  0, 9'b001100100, 9'h1FF, 0};
        vecs[5]  = '{88,   1'b1, 0,   1, 9'b101111000, 9'h1FF, 0};
        vecs[6]  = '{352,  1'b1, 0,   4, 9'b101100010, 9'h1FF, 0};
        vecs[7]  = '{353,  1'b1, 0,   4, 9'b001100000, 9'h1FF, 1};
        vecs[8]  = '{440,  1'b1, 0,   5, 9'b101000000, 9'h1FF, 1};
        vecs[9]  = '{528,  1'b1, 0,   6, 9'b101101000, 9'h1FF, 1};
        vecs[10] = '{616,  1'b1, 0,   0, 9'b101111001, 9'h1FF, 1};
        vecs[11] = '{1280, 1'b0, 640, 0, 9'b101100000, 9'h1FF, 0};
        vecs[12] = '{1311, 1'b0, 655, 0, 9'b011100000, 9'h1FF, 0};
        vecs[13] = '{1312, 1'b0, 656, 0, 9'b100100000, 9'h1FF, 0};
        vecs[14] = '{1503, 1'b0, 751, 0, 9'b010100000, 9'h1FF, 0};
        vecs[15] = '{1504, 1'b0, 752, 0, 9'b101100000, 9'h1FF, 0};
        vecs[16] = '{1585, 1'b1, 0,   4, 9'b001100000, 9'h1FF, 3};
        vecs[17] = '{1594, 1'b0, 797, 0, 9'b101100000, 9'h1FF, 0};
        vecs[18] = '{1595, 1'b0, 797, 0, 9'b011100100, 9'h1FF, 0};
        vecs[19] = '{1600, 1'b0, 0,   1, 9'b101111000, 9'h1FF, 0};

        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            guard = 0;
            while (last_t < vecs[i].t && guard < 4000) begin
                applyStimulus(1'b0, 1'b1, 1'b0);
                guard++;
            end
            s = vecs[i].sel ? samp_b : samp_a;
            checkValue($sformatf("vec%0d_t", i), last_t, vecs[i].t);
            checkValue($sformatf("vec%0d_x", i), int'(s.pix_x), vecs[i].x);
            checkValue($sformatf("vec%0d_y", i), int'(s.pix_y), vecs[i].y);
            checkValue($sformatf("vec%0d_flags", i), int'(flagsOf(s) & vecs[i].mask),
                       int'(vecs[i].flags & vecs[i].mask));
            if (vecs[i].fc >= 0)
                checkValue($sformatf("vec%0d_fc", i), int'(s.frame_count), vecs[i].fc);
        end

        // Freeze at pix_x=100 of line 1 and confirm the line still takes 1600 enabled clocks.
        $display("[TB] enable drop at pix_x=100");
        cnt = 1;
        guard = 0;
        while (last_t < 1799 && guard < 400) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            cnt++;
            guard++;
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkValue("freeze_x", int'(samp_a.pix_x), 100);
            checkValue("freeze_pulses", int'({flagsOf(samp_a) & 9'h10F, flagsOf(samp_b) & 9'h10F}), 0);
        end
        guard = 0;
        seen = 1'b0;
        while (!seen && guard < 2000) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (samp_a.render_start && samp_a.pix_y == 10'd2) seen = 1'b1;
            else cnt++;
            guard++;
        end
        checkValue("line_len", cnt, 1600);

        // Asynchronous reset mid-line must clear everything before the next clock edge.
        $display("[TB] reset mid-frame");
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkValue("rst_x_a", int'(samp_a.pix_x), 0);
        checkValue("rst_y_a", int'(samp_a.pix_y), 0);
        checkValue("rst_fc_b", int'(samp_b.frame_count), 0);
        checkValue("rst_pulses", int'({flagsOf(samp_a) & 9'h10F, flagsOf(samp_b) & 9'h10F}), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("post_rst_fs_a", int'(samp_a.frame_start), 1);
        checkValue("post_rst_fs_b", int'(samp_b.frame_start), 1);

`ifdef VGA_TIMING_LINE_IRQ_EN
        $display("[TB] line interrupt");
        guard = 0;
        while (last_t < 263 && guard < 400) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            guard++;
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkValue("irq_line_y", int'(samp_b.pix_y), 3);
        checkValue("irq_before", int'(samp_b.irq_pending), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("irq_set_wins", int'(samp_b.irq_pending), 1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("irq_sticky", int'(samp_b.irq_pending), 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("irq_cleared", int'(samp_b.irq_pending), 0);
        irq_line = 10'd600;
        seen = 1'b0;
        for (int k = 0; k < 700; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            seen = seen | samp_a.irq_pending | samp_b.irq_pending;
        end
        checkValue("irq_out_of_range", int'(seen), 0);
`else
        irq_line = 10'd1;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            seen = seen | samp_a.irq_pending | samp_b.irq_pending;
        end
        checkValue("irq_tied_off", int'(seen), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
